bram_stream_reader: RTL and testbench

- Read-side master for the team's simple dual-port `bram`.
- On a start command it issues `rd_en`/`rd_add` sequences and absorbs the BRAM's fixed 1-cycle read latency.
- It presents the words as a valid/ready stream with full backpressure support.
- It sits between the BRAM read port and any downstream consumer (DMA, UART TX, checksum engine).

---
 rtl/bram_rd_pkg.sv | 19 +
 rtl/bram_rd_skid.sv | 52 +++++
 rtl/bram_stream_reader.sv | 115 +++++++++++
 tb/tb_bram_stream_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM stream reader: FSM encoding and a
// parameter sanity helper.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry {data,last} FIFO that absorbs words already in flight from the
// BRAM when the downstream consumer stalls.
module bram_rd_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH-1:0] mem_data [2];
    logic             mem_last [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Callers never push when full nor pop when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side master for the simple dual-port bram: issues read bursts and
// turns the 1-cycle-latency read data into a backpressured stream.
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LENGHT = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_add,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last,
    output state_t            dbg_state
);

    if (ADDR_W != clog2_f(LENGHT)) begin : g_bad_addr_w
        $error("bram_stream_reader: ADDR_W must equal log2(LENGHT)");
    end

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   out_left;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        fill_now;
    logic [2:0]        room_lim;

    // Stream handshake: a word transfers on every rising edge where
    // m_valid && m_ready; while m_valid is high and m_ready low the head
    // word (m_data, m_last) is held unchanged and m_valid never drops.
    assign pop = m_valid && m_ready;

    // Reads already buffered or in flight, minus the word leaving now,
    // must leave a free slot for the word a new read would return.
    assign fill_now = {1'b0, occ} + {2'b00, inflight};
    assign room_lim = 3'd2 + {2'b00, pop};
    assign rd_en    = (state == S_RUN) && (issue_left != '0) && (fill_now < room_lim);
    assign rd_add   = rd_en ? addr : '0;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign m_valid   = (occ != 2'd0);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            issue_left    <= '0;
            out_left      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && (issue_left == CNT_ONE);
            if (rd_en) begin
                addr       <= addr + ADDR_ONE;
                issue_left <= issue_left - CNT_ONE;
            end
            if (pop) begin
                out_left <= out_left - CNT_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= base_add;
                        issue_left <= count;
                        out_left   <= count;
                        state      <= (count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd_en && issue_left == CNT_ONE) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && out_left == CNT_ONE) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    bram_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (rd_data),
        .push_last (inflight_last),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data),
        .head_last (m_last)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle BRAM.
module tb_bram_stream_reader;
  import bram_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  base_add = '0;
  logic [3:0]  count = '0;
  logic        busy, done, rd_en, m_valid, m_last;
  logic [2:0]  rd_add;
  logic [31:0] rd_data = '0;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  state_t      dbg_state;

  bram_stream_reader #(.WIDTH(32), .LENGHT(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .base_add(base_add), .count(count),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_add(rd_add), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [31:0] mem [0:7];
  initial for (int k = 0; k < 8; k++) mem[k] = 32'hA000_0000 + k;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_add];

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  exp_a[$];
  logic [31:0] got_q[$];
  logic [2:0]  add_q[$];
  int first_rd_cyc, first_valid_cyc, last_cyc, last_cnt, done_cyc, done_cnt;
  int busy_cnt, stall_viol, room_viol;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [2:0] b, input int c);
    logic [2:0] a;
    exp_q.delete();
    exp_a.delete();
    for (int i = 0; i < c; i++) begin
      a = b + 3'(i);
      exp_a.push_back(a);
      exp_q.push_back(32'hA000_0000 + {29'd0, a});
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    check({tag, "_addr_len"}, add_q.size(), exp_a.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < exp_a.size() && i < add_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), add_q[i], exp_a[i]);
  endtask

  // driver: cycle 0 is the cycle in which start is high
  task automatic run_cmd(input logic [2:0] b, input logic [3:0] c, input int ready_pct,
                         input int restart_cyc, input int rst_cyc);
    int issued, popped, cyc;
    bit stalled, fin;
    logic [31:0] held_d;
    logic held_l;
    got_q.delete(); add_q.delete();
    first_rd_cyc = -1; first_valid_cyc = -1; last_cyc = -1; last_cnt = 0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; stall_viol = 0; room_viol = 0;
    issued = 0; popped = 0; cyc = 0; stalled = 0; fin = 0; held_d = '0; held_l = 0;
    while (!fin && cyc < 400) begin
      @(posedge clk); #1;
      start    = (cyc == 0) || (cyc == restart_cyc);
      base_add = (cyc == 0) ? b : 3'd0;
      count    = (cyc == 0) ? c : 4'd3;
      m_ready  = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (stalled && !(m_valid && m_data == held_d && m_last == held_l)) stall_viol++;
      if (rd_en) begin
        if (issued - popped - int'(m_valid && m_ready) >= 2) room_viol++;
        add_q.push_back(rd_add);
        issued++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        popped++;
        if (m_last) begin last_cyc = cyc; last_cnt++; end
      end
      stalled = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (busy) busy_cnt++;
      if (done) begin done_cyc = cyc; done_cnt++; fin = 1; end
      if (cyc == rst_cyc) begin rst = 1'b0; fin = 1; end
      cyc++;
    end
    if (!fin) check("timeout", 1, 0);
    if (rst_cyc < 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_add"}, rd_add, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // base 2, count 4, always ready
    build_exp(3'd2, 4);
    run_cmd(3'd2, 4'd4, 100, -1, -1);
    compare_stream("basic");
    check("basic_first_rd", first_rd_cyc, 1);
    check("basic_first_valid", first_valid_cyc, 3);
    check("basic_last_cyc", last_cyc, 6);
    check("basic_last_cnt", last_cnt, 1);
    check("basic_done_cyc", done_cyc, 7);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_busy_cnt", busy_cnt, 7);

    // address wrap
    build_exp(3'd6, 4);
    run_cmd(3'd6, 4'd4, 100, -1, -1);
    compare_stream("wrap");
    check("wrap_last_cyc", last_cyc, 6);

    // full-depth burst with random backpressure
    build_exp(3'd0, 8);
    run_cmd(3'd0, 4'd8, 50, -1, -1);
    compare_stream("bp");
    check("bp_stall_stable", stall_viol, 0);
    check("bp_room", room_viol, 0);
    check("bp_last_cnt", last_cnt, 1);
    check("bp_done_cnt", done_cnt, 1);

    // zero-length command
    build_exp(3'd5, 0);
    run_cmd(3'd5, 4'd0, 100, -1, -1);
    check("zero_no_rd", add_q.size(), 0);
    check("zero_no_valid", first_valid_cyc < 0, 1);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_busy_cnt", busy_cnt, 1);
    check("zero_done_cnt", done_cnt, 1);

    // second start mid-command is ignored
    build_exp(3'd3, 4);
    run_cmd(3'd3, 4'd4, 100, 2, -1);
    compare_stream("restart");
    check("restart_done_cyc", done_cyc, 7);

    // reset during the third data cycle
    run_cmd(3'd0, 4'd8, 100, -1, 5);
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    build_exp(3'd1, 2);
    run_cmd(3'd1, 4'd2, 100, -1, -1);
    compare_stream("after_rst");
    check("after_rst_done_cnt", done_cnt, 1);
    check("after_rst_last_cnt", last_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
